fifo_rd_packer: RTL and testbench

Read-side consumer for the 4-bit tt_um_reemashivva_fifo read port. Pops words whenever the FIFO is not empty and packs WORDS consecutive words into one OUT_W-bit packet, first word in the LSBs. Presents each packet on a valid/ready output handshake. Sits between the FIFO read port and downstream byte-wide logic (e.g. a serializer).

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_rd_packer.sv | 130 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the 4-bit FIFO, its read-side packer and their benches.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2
    } rd_state_t;

    localparam int FIFO_WIDTH = 4;
    localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs WORDS of them (first word in the LSBs) into one valid/ready packet.
// Optional partial-packet flush (flush / m_words ports) is enabled by FIFO_RD_PACKER_FLUSH_EN.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int WORDS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [WIDTH-1:0]            fifo_rdata,
    output logic                        fifo_rd_en,
    output logic [WIDTH*WORDS-1:0]      m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
`ifdef FIFO_RD_PACKER_FLUSH_EN
    input  logic                        flush,
    output logic [$clog2(WORDS):0]      m_words,
`endif
    output logic [7:0]                  pkt_count,
    output logic                        busy
);

    localparam int OUT_W = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS - 1);
    localparam logic [IDX_W:0]   FULL_WORDS = (IDX_W + 1)'(WORDS);

    rd_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic [7:0]         pkt_count_q, pkt_count_d;
    logic [IDX_W:0]     m_words_q, m_words_d;
    logic               rd_en_s;

    // Next-state, packing and handshake logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        pkt_count_d = pkt_count_q;
        m_words_d   = m_words_q;
        rd_en_s     = 1'b0;
        case (state_q)
            FETCH: begin
`ifdef FIFO_RD_PACKER_FLUSH_EN
                // A flush of a partial packet takes priority over popping.
                if (flush && (idx_q != '0)) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (i >= int'(idx_q)) begin
                            m_data_d[i*WIDTH +: WIDTH] = '0;
                        end else begin
                            m_data_d[i*WIDTH +: WIDTH] = m_data_q[i*WIDTH +: WIDTH];
                        end
                    end
                    m_words_d = {1'b0, idx_q};
                    m_valid_d = 1'b1;
                    idx_d     = '0;
                    state_d   = PRESENT;
                end else
`endif
                if (!fifo_empty) begin
                    rd_en_s = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    state_d = FETCH;
                end
            end
            CAPTURE: begin
                m_data_d[int'(idx_q)*WIDTH +: WIDTH] = fifo_rdata;
                if (idx_q == LAST_IDX) begin
                    idx_d     = '0;
                    m_valid_d = 1'b1;
                    m_words_d = FULL_WORDS;
                    state_d   = PRESENT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH;
                end
            end
            PRESENT: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    pkt_count_d = pkt_count_q + 8'd1;
                    state_d     = FETCH;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            idx_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            pkt_count_q <= 8'd0;
            m_words_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            pkt_count_q <= pkt_count_d;
            m_words_q   <= m_words_d;
        end
    end

    assign fifo_rd_en = rd_en_s && !rst;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign pkt_count  = pkt_count_q;
    assign busy       = (idx_q != '0) || m_valid_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    assign m_words    = m_words_q;
`else
    logic unused_words_s;
    assign unused_words_s = ^m_words_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: queue-based FIFO model, word-grouping reference, negedge monitor.
module tb_fifo_rd_packer;

    localparam int WIDTH = fifo_rd_pkg::FIFO_WIDTH;
    localparam int WORDS = 2;
    localparam int OUT_W = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    logic               clk = 1'b0;
    logic               rst;
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_rdata;
    logic               fifo_rd_en;
    logic [OUT_W-1:0]   m_data;
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         pkt_count;
    logic               busy;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic               flush;
    logic [IDX_W:0]     m_words;
`endif

    fifo_rd_packer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef FIFO_RD_PACKER_FLUSH_EN
        .flush      (flush),
        .m_words    (m_words),
`endif
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model: words written by stimulus, popped on rd_en with one-cycle read latency.
    logic [WIDTH-1:0] mem [0:4095];
    int pushed_cnt = 0;
    int popped_cnt = 0;
    assign fifo_empty = (pushed_cnt == popped_cnt);

    typedef struct {
        logic [OUT_W-1:0] data;
        int               words;
    } exp_t;
    exp_t             exp_q[$];
    logic [WIDTH-1:0] pend_q[$];
    int               model_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Turn the pending words into one expected packet, zero-filling missing slots.
    function automatic void emit_expected();
        exp_t e;
        e.data  = '0;
        e.words = pend_q.size();
        for (int i = 0; i < pend_q.size(); i++) e.data[i*WIDTH +: WIDTH] = pend_q[i];
        exp_q.push_back(e);
        pend_q.delete();
    endfunction

    task automatic push(input logic [WIDTH-1:0] w);
        mem[pushed_cnt] = w;
        pushed_cnt++;
        pend_q.push_back(w);
        if (pend_q.size() == WORDS) emit_expected();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (fifo_rd_en) begin
                check("rd_en_while_empty", fifo_empty, 1'b0);
                check("rd_en_while_valid", m_valid, 1'b0);
                fifo_rdata <= mem[popped_cnt];
                popped_cnt <= popped_cnt + 1;
            end
        end
    end

    // Monitor: compares each accepted packet and checks hold-under-backpressure.
    initial begin
        logic             prev_hold;
        logic [OUT_W-1:0] prev_data;
        exp_t             e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_cnt = 0;
                prev_hold = 1'b0;
                check("rd_en_in_reset", fifo_rd_en, 1'b0);
            end else begin
                if (prev_hold) begin
                    check("valid_held", m_valid, 1'b1);
                    check("data_held", m_data, prev_data);
                end
                if (m_valid) check("pkt_count_live", pkt_count, model_cnt % 256);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_packet", m_data, 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("packet_data", m_data, e.data);
`ifdef FIFO_RD_PACKER_FLUSH_EN
                        check("packet_words", m_words, e.words);
`endif
                    end
                    model_cnt++;
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    task automatic wait_busy(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        check("wait_busy_timeout", seen, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy && fifo_empty;
        end
        check("wait_idle_timeout", done, 1'b1);
    endtask

    initial begin
        int n;
        int target;
        logic seen;
        rst     = 1'b1;
        m_ready = 1'b1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", m_valid, 1'b0);
        check("reset_data", m_data, '0);
        check("reset_count", pkt_count, 8'd0);
        check("reset_busy", busy, 1'b0);

        // Reset mid-packet: the captured word is discarded, a word pushed during reset starts slot 0.
        @(posedge clk); #1 push(4'h7);
        wait_busy(20);
        @(posedge clk); #1 rst = 1'b1;
        pend_q.delete();
        push(4'hE);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_valid", m_valid, 1'b0);
        check("mid_reset_data", m_data, '0);
        check("mid_reset_count", pkt_count, 8'd0);
        check("mid_reset_busy", busy, 1'b0);
        @(posedge clk); #1 push(4'hB);
        wait_idle(100);

        // Basic pack with m_ready high: first valid 2*WORDS+1 monitor samples after the push.
        @(posedge clk); #1 push(4'h3); push(4'hA);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = m_valid;
        end
        check("basic_latency", n, 2 * WORDS + 1);
        @(negedge clk);
        check("basic_valid_one_cycle", m_valid, 1'b0);
        wait_idle(100);
        check("basic_count", pkt_count, 8'd2);

        // Empty stall with a partial packet held.
        @(posedge clk); #1 push(4'h5);
        wait_busy(20);
        repeat (10) begin
            @(negedge clk);
            check("stall_busy", busy, 1'b1);
            check("stall_no_rd", fifo_rd_en, 1'b0);
        end
        @(posedge clk); #1 push(4'hC);
        wait_idle(100);

        // Backpressure: the first packet is held, reads stall.
        @(posedge clk); #1 m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(4'(i));
        repeat (20) @(negedge clk);
        check("bp_valid", m_valid, 1'b1);
        check("bp_data", m_data, 8'h21);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_idle(200);
        check("bp_count", pkt_count, 8'd7);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        @(posedge clk); #1 push(4'h9);
        wait_busy(20);
        @(posedge clk); #1 flush = 1'b1;
        emit_expected();
        @(posedge clk); #1 flush = 1'b0;
        wait_idle(100);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("flush_idle_no_pkt", m_valid, 1'b0);
        end
`endif

        // Random traffic up to the 256th accepted packet, then check the counter wrap.
        target = (256 - model_cnt) * WORDS;
        n = 0;
        while (n < target) begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push(4'($urandom));
                n++;
            end
        end
        @(posedge clk); #1 m_ready = 1'b1;
        wait_idle(5000);
        check("wrap_count", pkt_count, 8'h00);
        check("wrap_model_total", model_cnt, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
